// File: rtl/instr_encoder.sv
// instr_encoder: packs instruction requests into 32-bit MIPS words and streams them into instruction memory.
// Defining ENC_CHECKSUM_EN adds a csum output carrying the running XOR of every word written.
module instr_encoder #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned PAD_NOPS = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [4:0]        req_rs,
  input  logic [4:0]        req_rt,
  input  logic [4:0]        req_rd,
  input  logic [15:0]       req_imm,
  input  logic              finish,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [31:0]       csum
`endif
);

  typedef enum logic [1:0] {S_ACCEPT, S_PAD, S_FULL, S_DONE} state_e;

  typedef enum logic [3:0] {
    K_ADDU, K_SUBU, K_ADD, K_AND, K_OR, K_SLT,
    K_ADDI, K_ADDIU, K_ANDI, K_ORI, K_LUI
  } kind_e;

  localparam logic [ADDR_W:0] LAST_SLOT = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W:0]     wptr_q, wptr_d;
  logic [ADDR_W:0]     pad_cnt_q, pad_cnt_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [31:0]         im_wdata_q, im_wdata_d;
  logic                err_q, err_d;

  logic                accept, legal, wr_fire, last_slot, pad_last;
  logic [31:0]         enc_word;

  // The immediate goes in verbatim; LUI has no source operand so its rs field is zeroed.
  function automatic logic [31:0] encode(input logic [3:0] kind, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [15:0] imm);
    logic [31:0] word;
    word = '0;
    case (kind_e'(kind))
      K_ADDU:  word = {6'b000000, rs, rt, rd, 5'd0, 6'b100001};
      K_SUBU:  word = {6'b000000, rs, rt, rd, 5'd0, 6'b100011};
      K_ADD:   word = {6'b000000, rs, rt, rd, 5'd0, 6'b100000};
      K_AND:   word = {6'b000000, rs, rt, rd, 5'd0, 6'b100100};
      K_OR:    word = {6'b000000, rs, rt, rd, 5'd0, 6'b100101};
      K_SLT:   word = {6'b000000, rs, rt, rd, 5'd0, 6'b101010};
      K_ADDI:  word = {6'b001000, rs, rt, imm};
      K_ADDIU: word = {6'b001001, rs, rt, imm};
      K_ANDI:  word = {6'b001100, rs, rt, imm};
      K_ORI:   word = {6'b001101, rs, rt, imm};
      K_LUI:   word = {6'b001111, 5'd0, rt, imm};
      default: word = '0;
    endcase
    return word;
  endfunction

  assign req_ready = (state_q == S_ACCEPT);
  assign accept    = req_valid && req_ready;
  assign legal     = (req_kind <= 4'd10);
  assign wr_fire   = accept && legal;
  assign last_slot = (wptr_q == LAST_SLOT);
  assign pad_last  = (32'(pad_cnt_q) + 32'd1 >= PAD_NOPS);
  assign enc_word  = encode(req_kind, req_rs, req_rt, req_rd, req_imm);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_ACCEPT;
    else        state_q <= state_d;
  end

  // NOTE: each always_comb assigns defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = S_ACCEPT;
    end else begin
      case (state_q)
        S_ACCEPT: begin
          if (wr_fire && last_slot) state_d = finish ? S_DONE : S_FULL;
          else if (finish)          state_d = (PAD_NOPS == 0) ? S_DONE : S_PAD;
        end
        S_PAD:   if (last_slot || pad_last) state_d = S_DONE;
        S_FULL:  if (finish) state_d = S_DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    im_we_d    = 1'b0;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    wptr_d     = wptr_q;
    pad_cnt_d  = pad_cnt_q;
    err_d      = err_q;
    if (clear) begin
      wptr_d    = '0;
      pad_cnt_d = '0;
      err_d     = 1'b0;
    end else if (state_q == S_ACCEPT && accept) begin
      if (legal) begin
        im_we_d    = 1'b1;
        im_addr_d  = wptr_q[ADDR_W-1:0];
        im_wdata_d = enc_word;
        wptr_d     = wptr_q + ONE;
      end else begin
        err_d = 1'b1;
      end
    end else if (state_q == S_PAD) begin
      im_we_d    = 1'b1;
      im_addr_d  = wptr_q[ADDR_W-1:0];
      im_wdata_d = '0;
      wptr_d     = wptr_q + ONE;
      pad_cnt_d  = pad_cnt_q + ONE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      pad_cnt_q  <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      pad_cnt_q  <= pad_cnt_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      err_q      <= err_d;
    end
  end

  assign im_we    = im_we_q;
  assign im_addr  = im_addr_q;
  assign im_wdata = im_wdata_q;
  assign count    = wptr_q;
  assign full     = wptr_q[ADDR_W];
  assign done     = (state_q == S_DONE);
  assign err      = err_q;

`ifdef ENC_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;

  // Folds in the word on the same edge it is written, so csum always covers im_wdata when im_we is high.
  always_comb begin
    csum_d = csum_q;
    if (clear)        csum_d = '0;
    else if (im_we_d) csum_d = csum_q ^ im_wdata_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: encoding table, fill/pad/clear sequences on a 32-word and a
// 4-word instance, and a randomized run against a behavioural model (csum checked with ENC_CHECKSUM_EN).
module tb_instr_encoder;

  localparam int A_W   = 5;
  localparam int B_W   = 2;
  localparam int NOPS  = 2;
  localparam int DEPTH = 1 << A_W;
  localparam int FUNCT [6] = '{33, 35, 32, 36, 37, 42};
  localparam int IOP   [5] = '{8, 9, 12, 13, 15};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, clear, req_valid, finish, sel;
  logic [3:0]  req_kind;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic [15:0] req_imm;

  logic a_valid, a_finish, b_valid, b_finish;
  assign a_valid  = req_valid & ~sel;
  assign a_finish = finish & ~sel;
  assign b_valid  = req_valid & sel;
  assign b_finish = finish & sel;

  logic           a_ready, a_we, a_full, a_done, a_err;
  logic [A_W-1:0] a_addr;
  logic [31:0]    a_wdata;
  logic [A_W:0]   a_count;
  logic           b_ready, b_we, b_full, b_done, b_err;
  logic [B_W-1:0] b_addr;
  logic [31:0]    b_wdata;
  logic [B_W:0]   b_count;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]    a_csum, b_csum;
`endif

  instr_encoder #(.ADDR_W(A_W), .PAD_NOPS(NOPS)) dut_a (
    .clock(clock), .reset(reset), .clear(clear),
    .req_valid(a_valid), .req_ready(a_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .finish(a_finish), .im_we(a_we), .im_addr(a_addr), .im_wdata(a_wdata),
    .count(a_count), .full(a_full), .done(a_done), .err(a_err)
`ifdef ENC_CHECKSUM_EN
    , .csum(a_csum)
`endif
  );

  instr_encoder #(.ADDR_W(B_W), .PAD_NOPS(NOPS)) dut_b (
    .clock(clock), .reset(reset), .clear(clear),
    .req_valid(b_valid), .req_ready(b_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
    .finish(b_finish), .im_we(b_we), .im_addr(b_addr), .im_wdata(b_wdata),
    .count(b_count), .full(b_full), .done(b_done), .err(b_err)
`ifdef ENC_CHECKSUM_EN
    , .csum(b_csum)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    bit          legal;
    logic [31:0] word;
  } vec_t;

  vec_t vecs [13];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    finish    = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic send(input vec_t v);
    req_kind  = v.kind;
    req_rs    = v.rs;
    req_rt    = v.rt;
    req_rd    = v.rd;
    req_imm   = v.imm;
    req_valid = 1'b1;
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Behavioural reference: field layout from the ISA with plain arithmetic.
  function automatic logic [31:0] model_word(input int kind, input int rs, input int rt,
                                             input int rd, input int imm);
    int r;
    if (kind < 6) return 32'(rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + FUNCT[kind]);
    r = (kind == 10) ? 0 : rs;
    return 32'(IOP[kind - 6] * (1 << 26) + r * (1 << 21) + rt * (1 << 16) + imm);
  endfunction

  int          m_wptr, m_pads, m_addr;
  bit          m_closed, m_padding, m_err, m_we;
  logic [31:0] m_data, m_csum;

  function automatic bit model_ready();
    return !m_closed && !m_padding && (m_wptr < DEPTH);
  endfunction

  task automatic model_write(input logic [31:0] w);
    m_we   = 1'b1;
    m_addr = m_wptr;
    m_data = w;
    m_csum = m_csum ^ w;
    m_wptr++;
  endtask

  task automatic model_step();
    bit rdy;
    rdy  = model_ready();
    m_we = 1'b0;
    if (clear) begin
      m_wptr = 0; m_pads = 0; m_err = 1'b0;
      m_closed = 1'b0; m_padding = 1'b0; m_csum = '0;
    end else if (rdy) begin
      if (req_valid) begin
        if (req_kind <= 4'd10) model_write(model_word(int'(req_kind), int'(req_rs), int'(req_rt),
                                                      int'(req_rd), int'(req_imm)));
        else m_err = 1'b1;
      end
      if (finish) begin
        if (m_wptr == DEPTH || NOPS == 0) m_closed = 1'b1;
        else m_padding = 1'b1;
      end
    end else if (m_padding) begin
      model_write('0);
      m_pads++;
      if (m_pads == NOPS || m_wptr == DEPTH) begin
        m_padding = 1'b0;
        m_closed  = 1'b1;
      end
    end else if (!m_closed && finish) begin
      m_closed = 1'b1;
    end
  endtask

  initial begin
    vecs[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 1'b1, 32'h00221821};
    vecs[1]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'h0000, 1'b1, 32'h00853023};
    vecs[2]  = '{4'd9,  5'd0,  5'd8,  5'd31, 16'hABCD, 1'b1, 32'h3408ABCD};
    vecs[3]  = '{4'd10, 5'd5,  5'd1,  5'd0,  16'h1234, 1'b1, 32'h3C011234};
    vecs[4]  = '{4'd15, 5'd9,  5'd9,  5'd9,  16'h5555, 1'b0, 32'h0};
    vecs[5]  = '{4'd2,  5'd31, 5'd31, 5'd31, 16'hFFFF, 1'b1, 32'h03FFF820};
    vecs[6]  = '{4'd3,  5'd7,  5'd8,  5'd9,  16'h0000, 1'b1, 32'h00E84824};
    vecs[7]  = '{4'd4,  5'd10, 5'd11, 5'd12, 16'h0000, 1'b1, 32'h014B6025};
    vecs[8]  = '{4'd5,  5'd13, 5'd14, 5'd15, 16'h0000, 1'b1, 32'h01AE782A};
    vecs[9]  = '{4'd11, 5'd1,  5'd1,  5'd1,  16'h0001, 1'b0, 32'h0};
    vecs[10] = '{4'd6,  5'd1,  5'd2,  5'd0,  16'hFFFF, 1'b1, 32'h2022FFFF};
    vecs[11] = '{4'd7,  5'd3,  5'd4,  5'd0,  16'h8000, 1'b1, 32'h24648000};
    vecs[12] = '{4'd8,  5'd5,  5'd6,  5'd0,  16'h00FF, 1'b1, 32'h30A600FF};

    sel = 1'b0; reset = 1'b0;
    req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
    idle();
    tick();
    check("reset_flags_a", {a_ready, a_we, a_full, a_done, a_err}, 5'b10000);
    check("reset_addr_data_a", {a_addr, a_wdata, a_count}, '0);
    check("reset_flags_b", {b_ready, b_we, b_full, b_done, b_err, b_count}, {5'b10000, 3'd0});
    reset = 1'b1;
    tick();

    // First words, back to back
    send(vecs[0]); tick();
    check("addu_write", {a_we, a_addr, a_wdata, a_count}, {1'b1, 5'd0, 32'h00221821, 6'd1});
    send(vecs[1]); tick();
    check("subu_write", {a_we, a_addr, a_wdata}, {1'b1, 5'd1, 32'h00853023});
    send(vecs[2]); tick();
    check("ori_write", {a_we, a_addr, a_wdata}, {1'b1, 5'd2, 32'h3408ABCD});
    idle(); tick();
    check("idle_hold", {a_we, a_addr, a_wdata, a_count}, {1'b0, 5'd2, 32'h3408ABCD, 6'd3});
`ifdef ENC_CHECKSUM_EN
    check("csum_three", a_csum, 32'h00221821 ^ 32'h00853023 ^ 32'h3408ABCD);
`endif
    do_clear();
    check("clear_count", {a_count, a_ready, a_done, a_err}, {6'd0, 3'b100});
`ifdef ENC_CHECKSUM_EN
    check("csum_clear", a_csum, 32'h0);
`endif

    // Encoding table, applied back to back
    begin
      int  exp_addr;
      bit  seen_err;
      exp_addr = 0;
      seen_err = 1'b0;
      for (int i = 0; i < 13; i++) begin
        send(vecs[i]);
        tick();
        if (vecs[i].legal) begin
          check($sformatf("vec%0d_word", i), {a_we, a_addr, a_wdata},
                {1'b1, 5'(exp_addr), vecs[i].word});
          exp_addr++;
        end else begin
          check($sformatf("vec%0d_nowrite", i), a_we, 1'b0);
          seen_err = 1'b1;
        end
        check($sformatf("vec%0d_state", i), {a_err, a_count}, {seen_err, 6'(exp_addr)});
      end
    end
    do_clear();
    check("clear_err", a_err, 1'b0);

    // Three words, finish, two NOP pads
    for (int i = 0; i < 3; i++) begin send(vecs[i]); tick(); end
    idle(); finish = 1'b1; tick(); finish = 1'b0;
    check("pad_enter", {a_we, a_ready, a_done}, 3'b000);
    tick();
    check("pad0", {a_we, a_addr, a_wdata, a_count, a_done}, {1'b1, 5'd3, 32'h0, 6'd4, 1'b0});
    tick();
    check("pad1", {a_we, a_addr, a_wdata, a_count, a_done}, {1'b1, 5'd4, 32'h0, 6'd5, 1'b1});
    finish = 1'b1; send(vecs[0]); tick(); idle();
    check("done_hold", {a_we, a_done, a_ready, a_count}, {3'b010, 6'd5});
    clear = 1'b1; send(vecs[0]); tick(); idle();
    check("clear_drop", {a_we, a_done, a_ready, a_count}, {3'b001, 6'd0});

    // Clear in the middle of padding
    send(vecs[0]); tick(); idle();
    finish = 1'b1; tick(); finish = 1'b0;
    tick();
    check("midpad_write", {a_we, a_addr, a_count}, {1'b1, 5'd1, 6'd2});
    clear = 1'b1; send(vecs[1]); tick(); idle();
    check("midpad_clear", {a_we, a_ready, a_done, a_count}, {3'b010, 6'd0});
    tick();
    check("midpad_quiet", {a_we, a_count}, {1'b0, 6'd0});

    // Request and finish in the same cycle
    send(vecs[1]); finish = 1'b1; tick(); idle();
    check("fin_req_write", {a_we, a_addr, a_wdata, a_ready}, {1'b1, 5'd0, 32'h00853023, 1'b0});
    tick();
    tick();
    check("fin_req_pads", {a_we, a_addr, a_wdata, a_done, a_count}, {1'b1, 5'd2, 32'h0, 1'b1, 6'd3});
    do_clear();

    // Small memory: fill, stall, finish while full
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vecs[i]); tick();
      check($sformatf("b_fill%0d", i), {b_we, b_addr, b_wdata}, {1'b1, 2'(i), vecs[i].word});
    end
    check("b_full", {b_full, b_ready, b_count}, {2'b10, 3'd4});
    send(vecs[5]);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("b_stall%0d", i), {b_we, b_ready, b_count}, {2'b00, 3'd4});
    end
    finish = 1'b1; tick();
    check("b_full_finish", {b_we, b_done, b_full}, 3'b011);
    idle(); tick();
    check("b_done_hold", {b_we, b_done, b_count}, {2'b01, 3'd4});
    do_clear();
    check("b_clear", {b_full, b_done, b_ready, b_count}, {3'b001, 3'd0});

    // Last slot written together with finish
    for (int i = 0; i < 3; i++) begin send(vecs[i]); tick(); end
    send(vecs[3]); finish = 1'b1; tick(); idle();
    check("b_last_fin", {b_we, b_addr, b_done, b_full}, {1'b1, 2'd3, 2'b11});
    tick();
    check("b_last_fin_quiet", {b_we, b_done}, 2'b01);
    do_clear();

    // Padding cut short by the end of memory
    for (int i = 0; i < 3; i++) begin send(vecs[i]); tick(); end
    idle(); finish = 1'b1; tick(); finish = 1'b0;
    check("b_pad_enter", {b_we, b_done}, 2'b00);
    tick();
    check("b_pad_cut", {b_we, b_addr, b_wdata, b_done, b_full, b_count},
          {1'b1, 2'd3, 32'h0, 2'b11, 3'd4});
    tick();
    check("b_pad_stop", {b_we, b_done}, 2'b01);
    do_clear();
    sel = 1'b0;

    // Randomized run against the behavioural model
    reset = 1'b0; tick(); reset = 1'b1;
    m_wptr = 0; m_pads = 0; m_addr = 0; m_closed = 1'b0; m_padding = 1'b0;
    m_err = 1'b0; m_we = 1'b0; m_data = '0; m_csum = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      req_valid = ($urandom_range(0, 99) < 70);
      req_kind  = 4'($urandom_range(0, 15));
      req_rs    = 5'($urandom);
      req_rt    = 5'($urandom);
      req_rd    = 5'($urandom);
      req_imm   = 16'($urandom);
      finish    = ($urandom_range(0, 99) < 4);
      clear     = ($urandom_range(0, 99) < 3);
      check("rand_ready", a_ready, model_ready());
      tick();
      model_step();
      check("rand_status", {a_we, a_full, a_done, a_err, a_count},
            {m_we, (m_wptr == DEPTH), m_closed, m_err, 6'(m_wptr)});
      check("rand_word", {a_addr, a_wdata}, {5'(m_addr), m_data});
`ifdef ENC_CHECKSUM_EN
      check("rand_csum", a_csum, m_csum);
`endif
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
